// File: rtl/game_pkg.sv
// Shared game-core types: direction encoding and button channel indices.
package game_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RIGHT   = 3;
  localparam int BTN_PAUSE   = 4;
  localparam int BTN_RESTART = 5;

endpackage

// File: rtl/input_ctrl_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced
// level and a one-cycle press pulse on each accepted rising edge.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // Any return to the current level restarts the stability window.
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= ~level_q;
          press_q <= ~level_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/input_ctrl.sv
// Pad input front-end: per-channel debounce plus a direction FIFO popped on
// each game tick. INPUT_CTRL_REVERSE_FILTER_EN also drops 180-degree turns.
module input_ctrl
  import game_pkg::*;
#(
  parameter int NUM_BUTTONS     = 6,
  parameter int DEBOUNCE_CYCLES = 4096,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BUTTONS-1:0]       i_buttons,
  input  logic                         i_tick,
  input  logic                         i_clear,
  output logic [NUM_BUTTONS-1:0]       o_level,
  output logic [NUM_BUTTONS-1:0]       o_press,
  output logic [1:0]                   o_heading,
  output logic                         o_heading_upd,
  output logic [$clog2(QUEUE_DEPTH):0] o_queue_count,
  output logic                         o_queue_full
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_btn
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (i_buttons[k]),
      .level_o (o_level[k]),
      .press_o (o_press[k])
    );
  end

  logic [1:0]    mem_q [QUEUE_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    tail_q, tail_d, heading_q, heading_d;
  logic          upd_q, upd_d;

  logic       cand_vld, drop, full, push, pop;
  logic [1:0] cand, ref_dir;

  always_comb begin
    cand_vld = |o_press[3:0];
    cand     = DIR_UP;
    if      (o_press[BTN_UP])   cand = DIR_UP;
    else if (o_press[BTN_DOWN]) cand = DIR_DOWN;
    else if (o_press[BTN_LEFT]) cand = DIR_LEFT;
    else                        cand = DIR_RIGHT;

    ref_dir = (count_q != '0) ? tail_q : heading_q;
    drop    = (cand == ref_dir);
`ifdef INPUT_CTRL_REVERSE_FILTER_EN
    drop    = drop || (cand == (ref_dir ^ 2'd1));
`endif
    full = (count_q == CW'(QUEUE_DEPTH));
    // Pop decides on the pre-push occupancy; a pop frees a slot for a push.
    pop  = i_tick && (count_q != '0);
    push = cand_vld && !drop && (!full || pop);

    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    tail_d    = tail_q;
    heading_d = heading_q;
    upd_d     = 1'b0;

    if (i_clear) begin
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      heading_d = DIR_RESET;
    end else begin
      if (push) begin
        wptr_d = wptr_q + 1'b1;
        tail_d = cand;
      end
      if (pop) begin
        rptr_d    = rptr_q + 1'b1;
        heading_d = mem_q[rptr_q];
        upd_d     = 1'b1;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      tail_q    <= DIR_RESET;
      heading_q <= DIR_RESET;
      upd_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      tail_q    <= tail_d;
      heading_q <= heading_d;
      upd_q     <= upd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !i_clear) mem_q[wptr_q] <= cand;
  end

  assign o_heading     = heading_q;
  assign o_heading_upd = upd_q;
  assign o_queue_count = count_q;
  assign o_queue_full  = (count_q == CW'(QUEUE_DEPTH));

endmodule

// File: tb/tb_input_ctrl.sv
// Directed bench for input_ctrl: debounce timing, FIFO ordering, drops,
// simultaneous push/pop/clear and reset during debounce.
module tb_input_ctrl;

  localparam int NB = 6;
  localparam int DC = 4;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst, tick, clr;
  logic [NB-1:0] buttons;
  logic [NB-1:0] level, press;
  logic [1:0]    heading;
  logic          upd, full;
  logic [2:0]    count;

  input_ctrl #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DC), .QUEUE_DEPTH(QD)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_buttons     (buttons),
    .i_tick        (tick),
    .i_clear       (clr),
    .o_level       (level),
    .o_press       (press),
    .o_heading     (heading),
    .o_heading_upd (upd),
    .o_queue_count (count),
    .o_queue_full  (full)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [NB-1:0] mask;
    bit            tk;
    bit            cl;
    int            cnt;
    int            head;
    int            upd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [NB-1:0] m, input bit t, input bit c,
                     input int cn, input int h, input int u);
    vec_t v;
    v.mask = m; v.tk = t; v.cl = c; v.cnt = cn; v.head = h; v.upd = u;
    vecs.push_back(v);
  endtask

  // Called #1 after a posedge. A press is visible 2+DC edges after the raw
  // edge; tick/clear ride that same cycle so they coincide with the push.
  task automatic apply(input vec_t v, input int idx);
    if (v.mask != '0) begin
      buttons = v.mask;
      repeat (DC + 2) @(posedge clk);
      #1;
      chk($sformatf("v%0d press", idx), int'(press), int'(v.mask));
    end
    tick = v.tk;
    clr  = v.cl;
    @(posedge clk);
    #1;
    tick = 1'b0;
    clr  = 1'b0;
    chk($sformatf("v%0d count", idx), int'(count), v.cnt);
    chk($sformatf("v%0d full", idx), int'(full), (v.cnt == QD) ? 1 : 0);
    chk($sformatf("v%0d heading", idx), int'(heading), v.head);
    chk($sformatf("v%0d upd", idx), int'(upd), v.upd);
    if (v.mask != '0) begin
      buttons = '0;
      repeat (DC + 4) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen, npress;
    rst = 1'b1; tick = 1'b0; clr = 1'b0; buttons = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst level", int'(level), 0);
    chk("rst press", int'(press), 0);
    chk("rst heading", int'(heading), 3);
    chk("rst upd", int'(upd), 0);
    chk("rst count", int'(count), 0);
    chk("rst full", int'(full), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 3-cycle glitch must be swallowed.
    buttons[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 buttons[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (level[0] || press[0]) seen++;
    end
    chk("glitch blocked", seen, 0);

    // Stable press: level rises 2+DC edges after the raw edge, one pulse.
    buttons[0] = 1'b1;
    npress = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (press[0]) npress++;
      if (i == 5) chk("level before latency", int'(level[0]), 0);
      if (i == 6) begin
        chk("level at latency", int'(level[0]), 1);
        chk("press at latency", int'(press[0]), 1);
      end
    end
    chk("single press pulse", npress, 1);
    buttons[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    add(6'b000000, 0, 1, 0, 3, 0);
    // Up, left, down then three ticks.
    add(6'b000001, 0, 0, 1, 3, 0);
    add(6'b000100, 0, 0, 2, 3, 0);
    add(6'b000010, 0, 0, 3, 3, 0);
    add(6'b000000, 1, 0, 2, 0, 1);
    add(6'b000000, 1, 0, 1, 2, 1);
    add(6'b000000, 1, 0, 0, 1, 1);
    add(6'b000000, 0, 1, 0, 3, 0);
    // Fill to full, fifth press dropped, drain, empty tick.
    add(6'b000001, 0, 0, 1, 3, 0);
    add(6'b000100, 0, 0, 2, 3, 0);
    add(6'b000001, 0, 0, 3, 3, 0);
    add(6'b000100, 0, 0, 4, 3, 0);
    add(6'b000001, 0, 0, 4, 3, 0);
    add(6'b000000, 1, 0, 3, 0, 1);
    add(6'b000000, 1, 0, 2, 2, 1);
    add(6'b000000, 1, 0, 1, 0, 1);
    add(6'b000000, 1, 0, 0, 2, 1);
    add(6'b000000, 1, 0, 0, 2, 0);
    // Push+pop at 2 entries, then at full.
    add(6'b000001, 0, 0, 1, 2, 0);
    add(6'b001000, 0, 0, 2, 2, 0);
    add(6'b000010, 1, 0, 2, 0, 1);
    add(6'b000100, 0, 0, 3, 0, 0);
    add(6'b000001, 0, 0, 4, 0, 0);
    add(6'b001000, 1, 0, 4, 3, 1);
    // Down to 3 entries, then clear beats tick and press.
    add(6'b000000, 1, 0, 3, 1, 1);
    add(6'b000010, 1, 1, 0, 3, 0);
    // Same as heading: dropped.
    add(6'b001000, 0, 0, 0, 3, 0);
`ifdef INPUT_CTRL_REVERSE_FILTER_EN
    add(6'b000100, 0, 0, 0, 3, 0);
    add(6'b000000, 1, 0, 0, 3, 0);
    // Down and left together: down wins.
    add(6'b000110, 0, 0, 1, 3, 0);
`else
    add(6'b000100, 0, 0, 1, 3, 0);
    add(6'b000000, 1, 0, 0, 2, 1);
    add(6'b000110, 0, 0, 1, 2, 0);
`endif
    add(6'b000000, 1, 0, 0, 1, 1);
    // Generic channel never enters the queue.
    add(6'b010000, 0, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset in the middle of a debounce window restarts the count.
    buttons[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid rst level", int'(level[1]), 0);
    chk("mid rst heading", int'(heading), 3);
    chk("mid rst count", int'(count), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("post rst level early", int'(level[1]), 0);
    @(posedge clk); #1;
    chk("post rst level", int'(level[1]), 1);
    buttons = '0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
